// File: rtl/mulacc_pkg.sv
// Shared widths and state encoding for the unsigned shift-add multiply-accumulate.
package mulacc_pkg;
    localparam int WIDTH_A = 32;
    localparam int WIDTH_B = 16;
    localparam int WIDTH_C = 5;
    localparam int PROD_W  = WIDTH_A + WIDTH_B;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/multiply_accumulate32_unsigned_shift_add_if.sv
// Operand/result bundle between a requester and the multiply-accumulate unit.
interface multiply_accumulate32_unsigned_shift_add_if;
    import mulacc_pkg::*;

    logic               start;
    logic [WIDTH_A-1:0] quotient;
    logic [WIDTH_B-1:0] divisor;
    logic [WIDTH_B-1:0] remainder;
    logic [PROD_W-1:0]  product;
    logic               wide;
    logic               ready;
    logic               busy;
    logic [WIDTH_C-1:0] count;

    modport master (
        output start, quotient, divisor, remainder,
        input  product, wide, ready, busy, count
    );
    modport slave (
        input  start, quotient, divisor, remainder,
        output product, wide, ready, busy, count
    );
endinterface

// File: rtl/mulacc_step.sv
// One shift-add iteration: conditionally add the shifted multiplicand, then advance a and b.
module mulacc_step
    import mulacc_pkg::*;
#(
    parameter int PW = PROD_W,
    parameter int BW = WIDTH_B
) (
    input  logic [PW-1:0] acc,
    input  logic [PW-1:0] a,
    input  logic [BW-1:0] b,
    output logic [PW-1:0] acc_next,
    output logic [PW-1:0] a_next,
    output logic [BW-1:0] b_next,
    output logic          b_next_zero
);
    assign acc_next    = b[0] ? acc + a : acc;
    assign a_next      = a << 1;
    assign b_next      = b >> 1;
    assign b_next_zero = (b_next == '0);
endmodule

// File: rtl/multiply_accumulate32_unsigned_shift_add.sv
// Sequential product = quotient * divisor + remainder, one multiplier bit per clock.
// Define MULACC_EARLY_EXIT_EN to stop as soon as the remaining multiplier bits are zero.
module multiply_accumulate32_unsigned_shift_add
    import mulacc_pkg::*;
(
    input logic clock,
    input logic reset,
    multiply_accumulate32_unsigned_shift_add_if.slave bus
);
    state_t             state;
    logic [PROD_W-1:0]  acc, a, acc_next, a_next;
    logic [WIDTH_B-1:0] b, b_next;
    logic               b_next_zero;
    logic [PROD_W-1:0]  product;
    logic               wide, ready, busy, last;
    logic [WIDTH_C-1:0] count;

    mulacc_step #(.PW(PROD_W), .BW(WIDTH_B)) step (
        .acc         (acc),
        .a           (a),
        .b           (b),
        .acc_next    (acc_next),
        .a_next      (a_next),
        .b_next      (b_next),
        .b_next_zero (b_next_zero)
    );

`ifdef MULACC_EARLY_EXIT_EN
    assign last = b_next_zero || (count == WIDTH_C'(WIDTH_B - 1));
`else
    assign last = (count == WIDTH_C'(WIDTH_B - 1));
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            acc     <= '0;
            a       <= '0;
            b       <= '0;
            count   <= '0;
            busy    <= 1'b0;
            ready   <= 1'b0;
            product <= '0;
            wide    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    acc   <= PROD_W'(bus.remainder);
                    a     <= PROD_W'(bus.quotient);
                    b     <= bus.divisor;
                    count <= '0;
                    busy  <= 1'b1;
                    ready <= 1'b0;
                    state <= RUN;
                end
                RUN: begin
                    acc   <= acc_next;
                    a     <= a_next;
                    b     <= b_next;
                    count <= count + WIDTH_C'(1);
                    // start is not looked at here, so a request on the final edge is dropped
                    if (last) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        ready   <= 1'b1;
                        product <= acc_next;
                        wide    <= |acc_next[PROD_W-1:WIDTH_A];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.product = product;
    assign bus.wide    = wide;
    assign bus.ready   = ready;
    assign bus.busy    = busy;
    assign bus.count   = count;
endmodule

// File: tb/tb_multiply_accumulate32_unsigned_shift_add.sv
// Directed and random checks of the multiply-accumulate against an arithmetic reference.
module tb_multiply_accumulate32_unsigned_shift_add;
    import mulacc_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clock = ~clock;

    multiply_accumulate32_unsigned_shift_add_if bus ();

    multiply_accumulate32_unsigned_shift_add dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    function automatic longint unsigned ref_product(input logic [31:0] q, input logic [15:0] d,
                                                    input logic [15:0] r);
        longint unsigned p;
        p = longint'(q) * longint'(d) + longint'(r);
        return p;
    endfunction

    function automatic int ref_iters(input logic [15:0] d);
        int n;
`ifdef MULACC_EARLY_EXIT_EN
        n = 1;
        for (int i = 0; i < 16; i++) if (d[i]) n = i + 1;
`else
        n = 16;
`endif
        return n;
    endfunction

    task automatic launch(input logic [31:0] q, input logic [15:0] d, input logic [15:0] r);
        bus.start     = 1'b1;
        bus.quotient  = q;
        bus.divisor   = d;
        bus.remainder = r;
        tick();
        cyc           = 0;
        bus.start     = 1'b0;
        bus.quotient  = $urandom;
        bus.divisor   = 16'($urandom);
        bus.remainder = 16'($urandom);
    endtask

    task automatic wait_count(input string tag, input int target);
        while (int'(bus.count) != target && cyc < 40) tick();
        if (cyc >= 40) check({tag, "_timeout"}, 64'(bus.count), 64'(target));
    endtask

    task automatic finish_op(input string tag, input logic [31:0] q, input logic [15:0] d,
                             input logic [15:0] r);
        longint unsigned p;
        p = ref_product(q, d, r);
        while (!bus.ready && cyc < 40) tick();
        check({tag, "_latency"}, 64'(cyc), 64'(ref_iters(d)));
        check({tag, "_product"}, 64'(bus.product), p);
        check({tag, "_wide"}, 64'(bus.wide), 64'(p[47:32] != 0));
        check({tag, "_count"}, 64'(bus.count), 64'(ref_iters(d)));
        check({tag, "_busy"}, 64'(bus.busy), 64'(0));
    endtask

    task automatic run_op(input string tag, input logic [31:0] q, input logic [15:0] d,
                          input logic [15:0] r);
        launch(q, d, r);
        check({tag, "_accept_busy"}, 64'(bus.busy), 64'(1));
        check({tag, "_accept_ready"}, 64'(bus.ready), 64'(0));
        check({tag, "_accept_count"}, 64'(bus.count), 64'(0));
        finish_op(tag, q, d, r);
    endtask

    initial begin
        logic [31:0] q;
        logic [15:0] d, r;
        longint unsigned p1;

        reset = 1'b1;
        bus.start = 1'b0;
        bus.quotient = '0;
        bus.divisor = '0;
        bus.remainder = '0;
        tick();
        tick();
        check("rst_product", 64'(bus.product), 64'(0));
        check("rst_wide", 64'(bus.wide), 64'(0));
        check("rst_ready", 64'(bus.ready), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_count", 64'(bus.count), 64'(0));
        reset = 1'b0;
        tick();

        run_op("t1", 32'h0000_0002, 16'hFFFF, 16'h0002);
        run_op("t2", 32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF);
        run_op("t3", 32'h1234_5678, 16'h0000, 16'h00AB);
        run_op("bit0", 32'hDEAD_BEEF, 16'h0001, 16'h1111);

        for (int i = 0; i < 8; i++) begin
            q = $urandom;
            d = 16'($urandom);
            r = 16'($urandom);
            if (i == 3) d = 16'h0005;
            run_op($sformatf("rnd%0d", i), q, d, r);
        end

        // start while busy is ignored
        launch(32'hCAFE_F00D, 16'h8001, 16'h0100);
        wait_count("t4", 5);
        bus.start = 1'b1;
        bus.quotient = 32'h1111_1111;
        bus.divisor = 16'h2222;
        bus.remainder = 16'h3333;
        tick();
        bus.start = 1'b0;
        check("t4_count_after_ignored", 64'(bus.count), 64'(6));
        check("t4_still_busy", 64'(bus.busy), 64'(1));
        finish_op("t4", 32'hCAFE_F00D, 16'h8001, 16'h0100);

        // start on the edge where ready rises is dropped
        p1 = ref_product(32'h0BAD_F00D, 16'hC003, 16'h0042);
        launch(32'h0BAD_F00D, 16'hC003, 16'h0042);
        wait_count("edge", ref_iters(16'hC003) - 1);
        bus.start = 1'b1;
        bus.quotient = 32'h7777_7777;
        bus.divisor = 16'h0003;
        bus.remainder = 16'h0001;
        tick();
        bus.start = 1'b0;
        check("edge_ready", 64'(bus.ready), 64'(1));
        check("edge_product", 64'(bus.product), p1);
        tick();
        check("edge_ready_held", 64'(bus.ready), 64'(1));
        check("edge_busy_idle", 64'(bus.busy), 64'(0));
        check("edge_count_held", 64'(bus.count), 64'(ref_iters(16'hC003)));
        check("edge_product_held", 64'(bus.product), p1);

        // reset mid-operation aborts
        launch(32'h8765_4321, 16'hFFF0, 16'h0FFF);
        wait_count("t5", 7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_busy", 64'(bus.busy), 64'(0));
        check("t5_ready", 64'(bus.ready), 64'(0));
        check("t5_count", 64'(bus.count), 64'(0));
        check("t5_product", 64'(bus.product), 64'(0));
        tick();
        check("t5_no_ready_pulse", 64'(bus.ready), 64'(0));
        run_op("t5_fresh", 32'h8765_4321, 16'hFFF0, 16'h0FFF);

        // back-to-back: new start while ready is high
        p1 = ref_product(32'h0F0F_0F0F, 16'h1234, 16'h5678);
        run_op("t6a", 32'h0F0F_0F0F, 16'h1234, 16'h5678);
        launch(32'h0000_FFFF, 16'hABCD, 16'h0001);
        check("t6_ready_drop", 64'(bus.ready), 64'(0));
        check("t6_product_held", 64'(bus.product), p1);
        finish_op("t6b", 32'h0000_FFFF, 16'hABCD, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
